// File: rtl/tadd_pkg.sv
// Shared definitions for the adder result receive path: default float widths,
// flag bit positions and the FIFO level-width helper.
package tadd_pkg;
  localparam int EXP_DEF   = 5;
  localparam int FRA_DEF   = 10;
  localparam int FLAG_W    = 3;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;

  // A level counter must represent 0..DEPTH inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: storage, wrap-around pointers and occupancy.
// The head entry is presented combinationally; the output reads zero when empty.
module sync_fifo_fwft
  import tadd_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [DW-1:0]             i_data,
  output logic [DW-1:0]             o_data,
  output logic [lvl_w(DEPTH)-1:0]   o_level,
  output logic                      o_empty,
  output logic                      o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_push && !i_pop)      r_level <= r_level + LW'(1);
      else if (!i_push && i_pop) r_level <= r_level - LW'(1);
    end
  end

  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/tadd_result_rx.sv
// Receives unstallable adder results into a FWFT FIFO and frames them into BURST-beat packets.
// Optional per-entry flag storage is enabled by defining TADD_RX_FLAG_EN.
module tadd_result_rx
  import tadd_pkg::*;
#(
  parameter int EXP   = EXP_DEF,
  parameter int FRA   = FRA_DEF,
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [EXP+FRA:0]         s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic [FLAG_W-1:0]        s_axis_flag,
  output logic [EXP+FRA:0]         m_axis_tdata,
  output logic [FLAG_W-1:0]        m_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                     overflow,
  input  logic                     ovf_clr
);
  localparam int W  = EXP + FRA + 1;
`ifdef TADD_RX_FLAG_EN
  localparam int EW = W + FLAG_W;
`else
  localparam int EW = W;
`endif
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_rd_entry;
  logic          r_overflow;
  logic [BW-1:0] r_beat;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_pop  = !w_empty && m_axis_tready;
  assign w_push = s_axis_tvalid && (!w_full || w_pop);
  assign w_drop = s_axis_tvalid && w_full && !w_pop;

`ifdef TADD_RX_FLAG_EN
  assign w_wr_entry   = {s_axis_flag, s_axis_tdata};
  assign m_axis_tuser = w_rd_entry[EW-1:W];
`else
  logic w_unused_flag;
  assign w_unused_flag = ^s_axis_flag;
  assign w_wr_entry    = s_axis_tdata;
  assign m_axis_tuser  = '0;
`endif

  sync_fifo_fwft #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (aclk),
    .i_rst   (aresetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wr_entry),
    .o_data  (w_rd_entry),
    .o_level (level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn)     r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) r_beat <= '0;
    else if (w_pop) r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + BW'(1);
  end

  assign m_axis_tdata  = w_rd_entry[W-1:0];
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tlast  = !w_empty && (r_beat == BEAT_LAST);
  assign overflow      = r_overflow;
endmodule

// File: tb/tb_tadd_result_rx.sv
// Self-checking bench for tadd_result_rx: directed scenarios plus a randomized run
// against a queue-based reference model of the receive FIFO and packet framing.
module tb_tadd_result_rx;
  localparam int EXP   = 5;
  localparam int FRA   = 10;
  localparam int W     = EXP + FRA + 1;
  localparam int DEPTH = 8;
  localparam int BURST = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b1;
  logic [W-1:0]    s_axis_tdata = '0;
  logic            s_axis_tvalid = 1'b0;
  logic [2:0]      s_axis_flag = '0;
  logic [W-1:0]    m_axis_tdata;
  logic [2:0]      m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b0;
  logic            m_axis_tlast;
  logic [LW-1:0]   level;
  logic            overflow;
  logic            ovf_clr = 1'b0;

  int vec = 0;
  int err = 0;

  // Reference model: arrival-ordered queue of {flag, data}, pop count since reset, sticky drop flag.
  logic [W+2:0] mq[$];
  int           m_pops = 0;
  logic         m_ovf = 1'b0;

  always #5 aclk = ~aclk;

  tadd_result_rx #(.EXP(EXP), .FRA(FRA), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_flag   (s_axis_flag),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .level         (level),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr)
  );

  function automatic logic exp_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [W-1:0] exp_data();
    logic [W+2:0] e;
    if (mq.size() == 0) return '0;
    e = mq[0];
    return e[W-1:0];
  endfunction

  function automatic logic [2:0] exp_user();
    logic [W+2:0] e;
    if (mq.size() == 0) return 3'b000;
    e = mq[0];
`ifdef TADD_RX_FLAG_EN
    return e[W+2:W];
`else
    return 3'b000;
`endif
  endfunction

  function automatic logic exp_last();
    return (mq.size() != 0) && ((m_pops % BURST) == BURST - 1);
  endfunction

  // Drive one cycle of inputs, advance across the clock edge, update the model, settle 1 time unit.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic [2:0] f,
                       input logic rdy, input logic clr);
    logic pop, push;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_flag   = f;
    m_axis_tready = rdy;
    ovf_clr       = clr;
    pop  = (mq.size() != 0) && rdy;
    push = v && ((mq.size() < DEPTH) || pop);
    @(posedge aclk);
    if (pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (push) mq.push_back({f, d});
    if (v && !push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    s_axis_tvalid = 1'b0;
    ovf_clr       = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_pops = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vec++; if (level !== '0) begin err++; $display("FAIL reset_level got=%0d exp=0", level); end
    vec++; if (m_axis_tvalid !== 1'b0) begin err++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    vec++; if (m_axis_tlast !== 1'b0) begin err++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    vec++; if (m_axis_tdata !== '0) begin err++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    vec++; if (m_axis_tuser !== '0) begin err++; $display("FAIL reset_tuser got=%b exp=0", m_axis_tuser); end
    @(negedge aclk);
    aresetn = 1'b0;
    model_reset();
    @(posedge aclk); #1;
  endtask

  task automatic test_order();
    logic [W-1:0] words [3];
    words[0] = 16'h3C00; words[1] = 16'h4000; words[2] = 16'h4200;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, words[i], 3'b000, 1'b1, 1'b0);
      vec++; if (m_axis_tvalid !== 1'b1) begin err++; $display("FAIL order_valid[%0d] got=%b exp=1", i, m_axis_tvalid); end
      vec++; if (m_axis_tdata !== words[i]) begin err++; $display("FAIL order_data[%0d] got=%h exp=%h", i, m_axis_tdata, words[i]); end
    end
    cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);
    vec++; if (level !== '0) begin err++; $display("FAIL order_level_end got=%0d exp=0", level); end
    vec++; if (m_axis_tvalid !== 1'b0) begin err++; $display("FAIL order_valid_end got=%b exp=0", m_axis_tvalid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, W'(16'h5100 + i), 3'b000, 1'b0, 1'b0);
      if (i == 7) begin
        vec++; if (level !== LW'(8)) begin err++; $display("FAIL ovf_level8 got=%0d exp=8", level); end
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    vec++; if (overflow !== 1'b1) begin err++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    vec++; if (level !== LW'(8)) begin err++; $display("FAIL ovf_level_hold got=%0d exp=8", level); end
    for (int i = 0; i < 8; i++) begin
      vec++; if (m_axis_tdata !== W'(16'h5100 + i)) begin err++; $display("FAIL ovf_readback[%0d] got=%h exp=%h", i, m_axis_tdata, W'(16'h5100 + i)); end
      cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);
    end
    vec++; if (overflow !== 1'b1) begin err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    cycle(1'b0, '0, 3'b000, 1'b0, 1'b1);
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(16'h6200 + i), 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 16'h6AAA, 3'b000, 1'b1, 1'b0);
    vec++; if (level !== LW'(8)) begin err++; $display("FAIL fullpp_level got=%0d exp=8", level); end
    vec++; if (overflow !== 1'b0) begin err++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
    vec++; if (m_axis_tdata !== 16'h6201) begin err++; $display("FAIL fullpp_head got=%h exp=6201", m_axis_tdata); end
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] e;
      e = (i == 7) ? 16'h6AAA : W'(16'h6201 + i);
      vec++; if (m_axis_tdata !== e) begin err++; $display("FAIL fullpp_drain[%0d] got=%h exp=%h", i, m_axis_tdata, e); end
      cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);
    end
  endtask

  task automatic test_burst();
    @(negedge aclk); aresetn = 1'b1; #1; model_reset();
    @(negedge aclk); aresetn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, W'(16'h1000 + k), 3'b000, 1'b1, 1'b0);
      vec++; if (m_axis_tdata !== W'(16'h1000 + k)) begin err++; $display("FAIL burst_data[%0d] got=%h exp=%h", k, m_axis_tdata, W'(16'h1000 + k)); end
      vec++; if (m_axis_tlast !== ((k % 4) == 0)) begin err++; $display("FAIL burst_tlast[%0d] got=%b exp=%b", k, m_axis_tlast, (k % 4) == 0); end
    end
    cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    // Two beats of the current packet already consumed; queue five more without popping.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(16'h2200 + i), 3'b000, 1'b0, 1'b0);
    vec++; if (level !== LW'(5)) begin err++; $display("FAIL rstmid_level_pre got=%0d exp=5", level); end
    #2 aresetn = 1'b1;
    #1;
    model_reset();
    vec++; if (m_axis_tvalid !== 1'b0) begin err++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
    vec++; if (level !== '0) begin err++; $display("FAIL rstmid_level got=%0d exp=0", level); end
    vec++; if (m_axis_tdata !== '0) begin err++; $display("FAIL rstmid_tdata got=%h exp=0", m_axis_tdata); end
    @(negedge aclk); aresetn = 1'b0;
    cycle(1'b1, 16'h2F00, 3'b000, 1'b0, 1'b0);
    vec++; if (m_axis_tlast !== 1'b0) begin err++; $display("FAIL rstmid_first_tlast got=%b exp=0", m_axis_tlast); end
    vec++; if (m_axis_tdata !== 16'h2F00) begin err++; $display("FAIL rstmid_first_data got=%h exp=2f00", m_axis_tdata); end
    cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic test_flags();
    logic [2:0] e;
`ifdef TADD_RX_FLAG_EN
    e = 3'b010;
`else
    e = 3'b000;
`endif
    cycle(1'b1, 16'h7C00, 3'b010, 1'b0, 1'b0);
    vec++; if (m_axis_tuser !== e) begin err++; $display("FAIL flags_tuser got=%b exp=%b", m_axis_tuser, e); end
    vec++; if (m_axis_tdata !== 16'h7C00) begin err++; $display("FAIL flags_tdata got=%h exp=7c00", m_axis_tdata); end
    cycle(1'b0, '0, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic v, rdy, clr;
      v   = ($urandom_range(0, 3) != 0);
      rdy = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 11) == 0);
      cycle(v, W'($urandom), 3'($urandom), rdy, clr);
      vec++; if (m_axis_tvalid !== exp_valid()) begin err++; $display("FAIL rnd_tvalid c=%0d got=%b exp=%b", c, m_axis_tvalid, exp_valid()); end
      vec++; if (m_axis_tdata !== exp_data()) begin err++; $display("FAIL rnd_tdata c=%0d got=%h exp=%h", c, m_axis_tdata, exp_data()); end
      vec++; if (m_axis_tuser !== exp_user()) begin err++; $display("FAIL rnd_tuser c=%0d got=%b exp=%b", c, m_axis_tuser, exp_user()); end
      vec++; if (m_axis_tlast !== exp_last()) begin err++; $display("FAIL rnd_tlast c=%0d got=%b exp=%b", c, m_axis_tlast, exp_last()); end
      vec++; if (level !== LW'(mq.size())) begin err++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, mq.size()); end
      vec++; if (overflow !== m_ovf) begin err++; $display("FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_burst();
    test_reset_mid();
    test_flags();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/tadd_result_rx.md
TADD_RESULT_RX -- requirements
Module: tadd_result_rx

Interface
REQ-001 Parameter: EXP, 5, exponent width of the half-precision-style float.
REQ-002 Parameter: FRA, 10, fraction width; data width W = EXP+FRA+1.
REQ-003 Parameter: DEPTH, 8, FIFO entries; power of two, at least 2.
REQ-004 Parameter: BURST, 4, beats per output packet; at least 1.
REQ-005 Port: aclk  in  1  clock; reset aresetn, asynchronous, active-high; clock aclk.
REQ-006 Port: aresetn  in  1  asynchronous active-high reset.
REQ-007 Port: s_axis_tdata  in  W  result word from the adder.
REQ-008 Port: s_axis_tvalid  in  1  result valid; there is no ready, so the sender cannot be stalled.
REQ-009 Port: s_axis_flag  in  3  {NaN, Inf, Zero} flags accompanying the word.
REQ-010 Port: m_axis_tdata  out  W  head-of-FIFO word.
REQ-011 Port: m_axis_tuser  out  3  head-of-FIFO flags.
REQ-012 Port: m_axis_tvalid  out  1  FIFO non-empty.
REQ-013 Port: m_axis_tready  in  1  downstream accept.
REQ-014 Port: m_axis_tlast  out  1  last beat of a BURST packet.
REQ-015 Port: level  out  clog2(DEPTH)+1  current occupancy.
REQ-016 Port: overflow  out  1  sticky dropped-word indicator.
REQ-017 Port: ovf_clr  in  1  synchronous clear of overflow.

Function
REQ-018 Push condition: s_axis_tvalid=1 AND (level<DEPTH OR pop this cycle).
- A word arriving while the FIFO is full is accepted when a pop occurs in the same cycle.
REQ-019 Pop condition: m_axis_tvalid AND m_axis_tready.
REQ-020 m_axis_tvalid SHALL equal (level!=0), with first-word-fall-through behaviour.
- A word pushed at edge N appears on m_axis in the cycle after edge N, i.e. write-to-output latency is 1 cycle.
REQ-021 m_axis_tdata and m_axis_tuser SHALL remain stable while tvalid=1 and tready=0.
REQ-022 Simultaneous push and pop SHALL leave level unchanged.
- Pointers wrap modulo DEPTH.
REQ-023 A push attempted when full without a pop SHALL drop the word and set overflow at the next edge.
- FIFO contents and level SHALL NOT change.
REQ-024 overflow SHALL clear on ovf_clr=1; if a drop occurs in the same cycle, set wins.
REQ-025 A beat counter (0..BURST-1) SHALL advance on each pop and wrap to 0 after BURST-1.
- m_axis_tlast = m_axis_tvalid AND (beat==BURST-1).
- With BURST=1, tlast = tvalid.
REQ-026 The block SHALL NOT modify data; each word leaves in arrival order, bit-exact.

Reset
REQ-027 While aresetn=1, all of the following SHALL hold asynchronously:
- level=0, m_axis_tvalid=0, m_axis_tlast=0, overflow=0;
- beat counter and pointers = 0;
- m_axis_tdata and m_axis_tuser = 0.
REQ-028 Reset mid-operation SHALL discard all FIFO contents.
- The first push after release begins a new packet at beat 0.
REQ-029 The FIFO storage array itself is not reset; only the pointers are.

Configuration
REQ-030 Macro TADD_RX_FLAG_EN defined:
- flags are stored per entry (entry width W+3);
- m_axis_tuser carries the stored flags of the head entry.
REQ-031 Macro TADD_RX_FLAG_EN undefined:
- entry width W, and s_axis_flag is ignored;
- m_axis_tuser is constant 0;
- all other behaviour is identical.

Structure
REQ-032 Shared package tadd_pkg SHALL hold:
- default EXP/FRA localparams;
- flag bit indices (ZERO=0, INF=1, NAN=2);
- the clog2-based level-width helper.
REQ-033 One sub-module, sync_fifo_fwft, SHALL implement storage, pointers and level.
- tadd_result_rx adds the overflow, burst-counter and tlast logic around it.

Verification
REQ-034 Push 3 words 0x3C00, 0x4000, 0x4200 with tready=1.
- Required: they emerge in order, each 1 cycle after its push; level returns to 0.
REQ-035 Hold tready=0 and push 9 words (DEPTH=8).
- Required: level=8; overflow=1 one edge after the 9th push; words 1-8 are read back intact.
- Then ovf_clr=1: overflow=0.
REQ-036 Fill to 8, then drive a push and a pop in the same cycle.
- Required: the new word is accepted, level stays 8, overflow stays 0.
REQ-037 Stream 10 words with tready=1 and BURST=4.
- Required: tlast on beats 4 and 8; beat 9 starts a new packet.
REQ-038 Assert aresetn with 5 words queued, mid-burst.
- Required: tvalid=0 and level=0 immediately; after release, the first new word has tlast=0 (beat 0).
REQ-039 With TADD_RX_FLAG_EN, push 0x7C00 with flag=3'b010.
- Required: m_axis_tuser=3'b010.
- Without the macro, m_axis_tuser=0 for the same stimulus.
